epp_ctrl: RTL
=============

// Module: epp_ctrl
// PURPOSE
//  EPP-protocol slave between the host parallel port and the snake game core.
//  Host writes a direction byte; the block emits a one-cycle epp_wr pulse with
//  a validated one-hot direction on epp_data, which the game consumes.
//  It also exposes score and game_over for host readback.
//  Strobes are asynchronous to clk and are 2-flop synchronised internally.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser depth on astb/dstb/pwr (minimum 2)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   reset, asynchronous, active-low
//  astb       in   1   EPP address strobe, active-low, async
//  dstb       in   1   EPP data strobe, active-low, async
//  pwr        in   1   EPP direction: 0 = host write, 1 = host read; async
//  db_in      in   8   EPP data bus, host to slave
//  db_out     out  8   EPP data bus, slave to host
//  db_oe      out  1   db_out drive enable, for the top-level tristate
//  pwait      out  1   EPP wait/acknowledge, active-high
//  epp_data   out  4   validated direction: 0001 R, 0010 U, 0100 L, 1000 D
//  epp_wr     out  1   one-clk strobe; epp_data is valid in that cycle
//  number     in   16  current score from the game
//  game_over  in   1   game-over flag from the game
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0 and addr_reg=0. FSM -> IDLE.
//   Any transaction in flight is abandoned; no epp_wr is issued.
//  s_astb, s_dstb, s_pwr: outputs of the SYNC_STAGES flops.
//  FSM states:
//   IDLE: wait until s_astb=1 and s_dstb=1, then go to READY.
//     This guarantees a strobe held low through reset is never acted on.
//   READY, selected on the strobes:
//     - Both strobes low: protocol error. Stay in READY and take no action.
//     - s_astb=0, s_pwr=0: addr_reg <= db_in. Go to ACK.
//     - s_astb=0, s_pwr=1: db_out <= addr_reg. Go to ACK_RD.
//     - s_dstb=0, s_pwr=0: register write (below). Go to ACK.
//     - s_dstb=0, s_pwr=1: db_out <= rdmux(addr_reg). Go to ACK_RD.
//   ACK: pwait=1. When the active strobe is seen high, pwait <= 0 and go to READY.
//   ACK_RD: db_oe=1 and pwait=1. When the strobe is seen high, db_oe <= 0 and
//     pwait <= 0 (same edge), then go to READY.
//  Latency:
//   db_in is sampled on the edge where the synchronised strobe is first seen low.
//   pwait rises on the next edge.
//   Pin-fall to pwait-rise is SYNC_STAGES+1 clks.
//   Pin-rise to pwait-fall is SYNC_STAGES+1 clks.
//  Register write (addr_reg==0 only):
//   When db_in[7:4]==0 and db_in[3:0] is one of {1,2,4,8}:
//     epp_data <= db_in[3:0] and epp_wr <= 1 for exactly one clk, coinciding
//     with the pwait rise.
//   Otherwise no pulse. The handshake still completes, and epp_data keeps its
//     previous value.
//   Writes to addr_reg!=0 are acknowledged and ignored.
//  Only one epp_wr pulse per strobe assertion, however long the strobe is held.
//  epp_data holds its value between pulses.
//  rdmux(addr):
//   0 -> {4'b0, epp_data}
//   1 -> number[7:0]
//   2 -> number[15:8]
//   3 -> {7'b0, game_over}
//   4..255 -> 8'h00
//  Read data is captured once, at the READY->ACK_RD edge, so it stays stable
//   while the host samples.
//  The host must not change pwr while a strobe is low. If it does, the change
//   is ignored until READY.
// TESTING
//  1. Hold rst=0 with dstb=0. Release rst.
//     -> no epp_wr and pwait=0 until dstb goes high.
//     Then a write of 0x02 to addr 0 -> epp_wr pulses once, epp_data=4'b0010.
//  2. Address write 0x00, then data write 0x08.
//     -> pwait rises 3 clks after dstb falls, with epp_wr=1 in that same cycle.
//     pwait falls 3 clks after dstb rises.
//  3. Data writes of 0x03, 0x18 and 0x00 to addr 0.
//     -> no epp_wr, epp_data unchanged, each handshake completes normally.
//  4. number=16'hBEEF, game_over=1. Read addrs 1, 2, 3, 9.
//     -> 0xEF, 0xBE, 0x01, 0x00, with db_oe=1 only while pwait=1.
//  5. Hold dstb low for 100 clks with data 0x04.
//     -> exactly one epp_wr.
//     Then drive astb and dstb low together -> no pwait and no state change.
//  6. Drop rst mid-read while in ACK_RD.
//     -> db_oe=0, pwait=0 and epp_wr=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/epp_ctrl.sv
// EPP slave linking the host parallel port to the snake game core.
// Validates one-hot direction writes and serves score/game-over reads.
module epp_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        astb,
    input  logic        dstb,
    input  logic        pwr,
    input  logic [7:0]  db_in,
    output logic [7:0]  db_out,
    output logic        db_oe,
    output logic        pwait,
    output logic [3:0]  epp_data,
    output logic        epp_wr,
    input  logic [15:0] number,
    input  logic        game_over
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        IDLE,
        READY,
        ACK,
        ACK_RD
    } state_t;

    logic [SS-1:0] sync_a;
    logic [SS-1:0] sync_d;
    logic [SS-1:0] sync_p;
    logic          s_astb;
    logic          s_dstb;
    logic          s_pwr;

    state_t      state;
    state_t      nxt_state;
    logic [7:0]  addr_reg;
    logic [7:0]  nxt_addr;
    logic [7:0]  nxt_db_out;
    logic        nxt_db_oe;
    logic        nxt_pwait;
    logic [3:0]  nxt_data;
    logic        nxt_wr;
    logic        act_addr;
    logic        nxt_act_addr;
    logic        dir_ok;
    logic [7:0]  rd_val;

    assign s_astb = sync_a[SS-1];
    assign s_dstb = sync_d[SS-1];
    assign s_pwr  = sync_p[SS-1];

    // Bring the asynchronous host strobes into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '0;
            sync_d <= '0;
            sync_p <= '0;
        end else begin
            sync_a <= {sync_a[SS-2:0], astb};
            sync_d <= {sync_d[SS-2:0], dstb};
            sync_p <= {sync_p[SS-2:0], pwr};
        end
    end

    // Direction byte is accepted only as a clean one-hot low nibble
    always_comb begin
        dir_ok = 1'b0;
        if (db_in[7:4] == 4'd0) begin
            case (db_in[3:0])
                4'd1, 4'd2, 4'd4, 4'd8: dir_ok = 1'b1;
                default:                dir_ok = 1'b0;
            endcase
        end
    end

    // Read-back mux for data reads, selected by the address register
    always_comb begin
        rd_val = 8'h00;
        case (addr_reg)
            8'd0:    rd_val = {4'b0, epp_data};
            8'd1:    rd_val = number[7:0];
            8'd2:    rd_val = number[15:8];
            8'd3:    rd_val = {7'b0, game_over};
            default: rd_val = 8'h00;
        endcase
    end

    // Handshake FSM: next state and next register values
    always_comb begin
        nxt_state    = state;
        nxt_addr     = addr_reg;
        nxt_db_out   = db_out;
        nxt_db_oe    = db_oe;
        nxt_pwait    = pwait;
        nxt_data     = epp_data;
        nxt_wr       = 1'b0;
        nxt_act_addr = act_addr;
        unique case (state)
            IDLE: begin
                if (s_astb && s_dstb) nxt_state = READY;
            end
            READY: begin
                if (!s_astb && !s_dstb) begin
                    nxt_state = READY;
                end else if (!s_astb) begin
                    nxt_act_addr = 1'b1;
                    nxt_pwait    = 1'b1;
                    if (s_pwr) begin
                        nxt_db_out = addr_reg;
                        nxt_db_oe  = 1'b1;
                        nxt_state  = ACK_RD;
                    end else begin
                        nxt_addr  = db_in;
                        nxt_state = ACK;
                    end
                end else if (!s_dstb) begin
                    nxt_act_addr = 1'b0;
                    nxt_pwait    = 1'b1;
                    if (s_pwr) begin
                        nxt_db_out = rd_val;
                        nxt_db_oe  = 1'b1;
                        nxt_state  = ACK_RD;
                    end else begin
                        if (addr_reg == 8'd0 && dir_ok) begin
                            nxt_data = db_in[3:0];
                            nxt_wr   = 1'b1;
                        end
                        nxt_state = ACK;
                    end
                end
            end
            ACK: begin
                if (act_addr ? s_astb : s_dstb) begin
                    nxt_pwait = 1'b0;
                    nxt_state = READY;
                end
            end
            ACK_RD: begin
                if (act_addr ? s_astb : s_dstb) begin
                    nxt_pwait = 1'b0;
                    nxt_db_oe = 1'b0;
                    nxt_state = READY;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_reg <= 8'd0;
            db_out   <= 8'd0;
            db_oe    <= 1'b0;
            pwait    <= 1'b0;
            epp_data <= 4'd0;
            epp_wr   <= 1'b0;
            act_addr <= 1'b0;
        end else begin
            state    <= nxt_state;
            addr_reg <= nxt_addr;
            db_out   <= nxt_db_out;
            db_oe    <= nxt_db_oe;
            pwait    <= nxt_pwait;
            epp_data <= nxt_data;
            epp_wr   <= nxt_wr;
            act_addr <= nxt_act_addr;
        end
    end

endmodule
